// File: rtl/ghash_core.sv
// GHASH engine for GCM: Y_i = (Y_{i-1} ^ X_i) * H over GF(2^128), bit-reflected
// (bit 127 = x0), consuming DIGIT bits of H per MULT cycle.
module ghash_core #(
    parameter int unsigned BLOCK_WIDTH = 128,
    parameter int unsigned DIGIT       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BLOCK_WIDTH-1:0] h_in,
    input  logic                   blk_valid,
    output logic                   blk_ready,
    input  logic [BLOCK_WIDTH-1:0] blk_in,
    input  logic                   blk_last,
    output logic [BLOCK_WIDTH-1:0] hash_out,
    output logic                   hash_valid,
    output logic                   busy
);

    localparam int unsigned CYCLES = BLOCK_WIDTH / DIGIT;
    localparam int unsigned CW     = $clog2(CYCLES);
    localparam int unsigned DL     = $clog2(DIGIT);
    localparam int unsigned IW     = $clog2(BLOCK_WIDTH);
    localparam logic [CW-1:0] CTR_LAST = CW'(CYCLES - 1);
    localparam logic [BLOCK_WIDTH-1:0] R = {8'hE1, {(BLOCK_WIDTH-8){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, MULT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BLOCK_WIDTH-1:0] h_q, h_d;
    logic [BLOCK_WIDTH-1:0] y_q, y_d;
    logic [BLOCK_WIDTH-1:0] v_q, v_d;
    logic [BLOCK_WIDTH-1:0] z_q, z_d;
    logic [BLOCK_WIDTH-1:0] hash_q, hash_d;
    logic [CW-1:0]          ctr_q, ctr_d;
    logic                   last_q, last_d;
    logic                   hv_q, hv_d;

    logic [BLOCK_WIDTH-1:0] zt, vt;
    logic [IW-1:0]          bidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            y_q     <= '0;
            v_q     <= '0;
            z_q     <= '0;
            hash_q  <= '0;
            ctr_q   <= '0;
            last_q  <= 1'b0;
            hv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            y_q     <= y_d;
            v_q     <= v_d;
            z_q     <= z_d;
            hash_q  <= hash_d;
            ctr_q   <= ctr_d;
            last_q  <= last_d;
            hv_q    <= hv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        y_d     = y_q;
        v_d     = v_q;
        z_d     = z_q;
        hash_d  = hash_q;
        ctr_d   = ctr_q;
        last_d  = last_q;
        hv_d    = 1'b0;
        bidx    = '0;
        zt      = z_q;
        vt      = v_q;

        // H bit for step j of this cycle sits at 127 - (ctr*DIGIT + j), i.e. the bitwise complement.
        for (int unsigned j = 0; j < DIGIT; j++) begin
            bidx = ~((IW'(ctr_q) << DL) + IW'(j));
            if (h_q[bidx]) zt = zt ^ vt;
            vt = vt[0] ? ((vt >> 1) ^ R) : (vt >> 1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    h_d     = h_in;
                    y_d     = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (blk_valid) begin
                    v_d     = y_q ^ blk_in;
                    z_d     = '0;
                    last_d  = blk_last;
                    ctr_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                z_d   = zt;
                v_d   = vt;
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == CTR_LAST) begin
                    y_d     = zt;
                    ctr_d   = '0;
                    state_d = last_q ? DONE : WAIT;
                end
            end
            DONE: begin
                hash_d  = y_q;
                hv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign blk_ready  = (state_q == WAIT);
    assign busy       = (state_q != IDLE);
    assign hash_out   = hash_q;
    assign hash_valid = hv_q;

endmodule

// File: tb/tb_ghash_core.sv
// Directed and randomized checks of ghash_core for DIGIT = 1, 2, 4, 8 against a
// polynomial-multiply GF(2^128) reference model.
module tb_ghash_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]   start_v, valid_v, ready_v, hv_v, busy_v;
    logic [127:0] h_in, blk_in;
    logic         blk_last;
    logic [127:0] hash_o [4];

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_hash [4];
    logic [127:0] blk_q [$];
    int           acc_q [$];

    localparam logic [127:0] ONE   = 128'h80000000_00000000_00000000_00000000;
    localparam logic [127:0] XID   = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] HTC2  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CTC2  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] LTC2  = 128'h00000000000000000000000000000080;
    localparam logic [127:0] GTC2  = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ghash_core #(.BLOCK_WIDTH(128), .DIGIT(1 << g)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .h_in(h_in),
            .blk_valid(valid_v[g]), .blk_ready(ready_v[g]), .blk_in(blk_in),
            .blk_last(blk_last), .hash_out(hash_o[g]), .hash_valid(hv_v[g]),
            .busy(busy_v[g])
        );
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Carry-less product of the two polynomials, then reduction by x^128+x^7+x^2+x+1.
    function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] p;
        logic [127:0] r;
        p = '0;
        for (int i = 0; i < 128; i++)
            if (a[127-i])
                for (int j = 0; j < 128; j++)
                    if (b[127-j]) p[i+j] = ~p[i+j];
        for (int k = 254; k >= 128; k--) begin
            if (p[k]) begin
                p[k]       = 1'b0;
                p[k-128]   = ~p[k-128];
                p[k-127]   = ~p[k-127];
                p[k-126]   = ~p[k-126];
                p[k-121]   = ~p[k-121];
            end
        end
        for (int i = 0; i < 128; i++) r[127-i] = p[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_hash(input int d, input logic [127:0] h, input int gap_max,
                           input bit poke, input bit hold_valid, output logic [127:0] res);
        int n, acc, lat;
        bit seen;
        logic [127:0] y;
        n = blk_q.size();
        acc = 0;
        y = '0;
        foreach (blk_q[i]) y = gf_mul(y ^ blk_q[i], h);
        acc_q.delete();

        @(posedge clk); #1;
        start_v[d] = 1'b1; h_in = h;
        @(posedge clk); #1;
        start_v[d] = 1'b0; h_in = rnd128();
        chk("hash_hold_after_start", hash_o[d], exp_hash[d]);
        chk("busy_in_wait", 128'(busy_v[d]), 128'(1));

        for (int i = 0; i < n; i++) begin
            if (!hold_valid && gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) @(posedge clk);
                #1;
            end
            blk_in = blk_q[i];
            blk_last = (i == n - 1);
            valid_v[d] = 1'b1;
            seen = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (ready_v[d]) begin seen = 1'b1; break; end
            end
            chk("accept_wait", 128'(seen), 128'(1));
            @(posedge clk); #1;
            acc = cyc;
            acc_q.push_back(acc);
            if (!hold_valid || i == n - 1) valid_v[d] = 1'b0;
            blk_in = rnd128();
            blk_last = 1'($urandom);
            if (poke && i == 0) begin
                repeat (5) @(posedge clk);
                #1;
                start_v[d] = 1'b1; h_in = rnd128();
                @(posedge clk); #1;
                start_v[d] = 1'b0;
            end
        end

        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (hv_v[d]) begin seen = 1'b1; break; end
        end
        chk("hash_valid_wait", 128'(seen), 128'(1));
        lat = cyc - acc;
        chk("latency", 128'(lat), 128'((128 >> d) + 1));
        chk("hash_value", hash_o[d], y);
        res = hash_o[d];
        exp_hash[d] = y;
        @(negedge clk);
        chk("hash_valid_one_cycle", 128'(hv_v[d]), 128'(0));
        chk("busy_after_done", 128'(busy_v[d]), 128'(0));
        chk("hash_hold_after_done", hash_o[d], y);
    endtask

    initial begin
        logic [127:0] res;
        int pulses;

        rst = 1'b1;
        start_v = '0; valid_v = '0;
        h_in = '0; blk_in = '0; blk_last = 1'b0;
        for (int d = 0; d < 4; d++) exp_hash[d] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_hash_out", hash_o[d], '0);
            chk("rst_hash_valid", 128'(hv_v[d]), 128'(0));
            chk("rst_busy", 128'(busy_v[d]), 128'(0));
            chk("rst_blk_ready", 128'(ready_v[d]), 128'(0));
        end
        rst = 1'b0;

        // blk_valid while idle must not be accepted
        @(posedge clk); #1;
        valid_v[0] = 1'b1; blk_in = rnd128(); blk_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_ready", 128'(ready_v[0]), 128'(0));
            chk("idle_busy", 128'(busy_v[0]), 128'(0));
        end
        @(posedge clk); #1;
        valid_v[0] = 1'b0;

        blk_q = '{XID};
        do_hash(0, ONE, 0, 1'b0, 1'b0, res);
        chk("identity", res, XID);

        blk_q = '{128'h0};
        do_hash(0, HTC2, 0, 1'b0, 1'b0, res);
        chk("zero", res, '0);

        blk_q = '{CTC2, LTC2};
        do_hash(0, HTC2, 2, 1'b0, 1'b0, res);
        chk("gcm_tc2", res, GTC2);

        blk_q = '{rnd128(), rnd128(), rnd128()};
        do_hash(0, rnd128(), 0, 1'b0, 1'b1, res);
        chk("throughput_1", 128'(acc_q[1] - acc_q[0]), 128'(129));
        chk("throughput_2", 128'(acc_q[2] - acc_q[1]), 128'(129));

        blk_q = '{rnd128(), rnd128()};
        do_hash(0, rnd128(), 0, 1'b1, 1'b0, res);

        // Reset partway through MULT aborts the hash
        @(posedge clk); #1;
        start_v[0] = 1'b1; h_in = ONE;
        @(posedge clk); #1;
        start_v[0] = 1'b0; blk_in = XID; blk_last = 1'b1; valid_v[0] = 1'b1;
        @(negedge clk);
        chk("abort_ready", 128'(ready_v[0]), 128'(1));
        @(posedge clk); #1;
        valid_v[0] = 1'b0;
        repeat (59) @(posedge clk);
        #1;
        chk("abort_busy_before", 128'(busy_v[0]), 128'(1));
        rst = 1'b1;
        #1;
        chk("abort_hash_out", hash_o[0], '0);
        chk("abort_hash_valid", 128'(hv_v[0]), 128'(0));
        chk("abort_busy", 128'(busy_v[0]), 128'(0));
        chk("abort_ready_low", 128'(ready_v[0]), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 4; d++) exp_hash[d] = '0;
        pulses = 0;
        repeat (200) begin
            @(negedge clk);
            if (hv_v[0]) pulses++;
        end
        chk("abort_no_hash_valid", 128'(pulses), 128'(0));

        blk_q = '{XID};
        do_hash(0, ONE, 0, 1'b0, 1'b0, res);
        chk("identity_after_reset", res, XID);

        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 16; k++) begin
                blk_q = '{rnd128(), rnd128(), rnd128(), rnd128()};
                do_hash(d, rnd128(), 2, 1'b0, 1'b0, res);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
